// File: rtl/block_accum_ctrl.sv
// Block accumulator: reads NUM_BLOCKS blocks of BLOCK_LEN words, writes each
// block sum after its data and the grand total to the top address.
module block_accum_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int BLOCK_LEN  = 4,
    parameter int NUM_BLOCKS = 5,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sat_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int EW = $clog2(BLOCK_LEN + 1);
    localparam int BW = $clog2(NUM_BLOCKS + 1);
    localparam int WW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, ACC, WR_BLK, WR_TOTAL, DONE
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] blk_sum, total;
    logic [ADDR_W-1:0] base;
    logic [EW-1:0]     elem_idx;
    logic [BW-1:0]     blk_idx;
    logic [WW-1:0]     wait_cnt;
    logic              sat_q, ovf_q;

    logic [DATA_W:0]   blk_add, tot_add;
    logic              last_wait, last_elem, last_blk;

    assign blk_add   = {1'b0, blk_sum} + {1'b0, mem_rdata};
    assign tot_add   = {1'b0, total} + {1'b0, blk_sum};
    assign last_wait = (wait_cnt == WW'(RD_LAT - 1));
    assign last_elem = (elem_idx == EW'(BLOCK_LEN - 1));
    assign last_blk  = (blk_idx == BW'(NUM_BLOCKS - 1));
    assign overflow  = ovf_q;

    // Carry clamps to all-ones only when the run latched saturating mode.
    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W:0] s, input logic sat);
        return (sat && s[DATA_W]) ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    // NOTE: every comb output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx  = state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE) && (state != DONE);
        case (state)
            IDLE:     if (start) state_nx = RD_REQ;
            RD_REQ: begin
                mem_rd_en = 1'b1;
                mem_addr  = base + ADDR_W'(elem_idx);
                state_nx  = RD_WAIT;
            end
            RD_WAIT:  if (last_wait) state_nx = ACC;
            ACC:      state_nx = last_elem ? WR_BLK : RD_REQ;
            WR_BLK: begin
                mem_wr_en = 1'b1;
                mem_addr  = base + ADDR_W'(BLOCK_LEN);
                mem_wdata = blk_sum;
                state_nx  = last_blk ? WR_TOTAL : RD_REQ;
            end
            WR_TOTAL: begin
                mem_wr_en = 1'b1;
                mem_addr  = '1;
                mem_wdata = total;
                state_nx  = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            blk_sum  <= '0;
            total    <= '0;
            base     <= '0;
            elem_idx <= '0;
            blk_idx  <= '0;
            wait_cnt <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    blk_sum  <= '0;
                    total    <= '0;
                    base     <= '0;
                    elem_idx <= '0;
                    blk_idx  <= '0;
                    wait_cnt <= '0;
                    sat_q    <= sat_en;
                    ovf_q    <= 1'b0;
                end
                RD_WAIT: begin
                    if (last_wait) begin
                        // Read data is valid in the last wait cycle.
                        blk_sum  <= fold(blk_add, sat_q);
                        ovf_q    <= ovf_q | blk_add[DATA_W];
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ACC:      elem_idx <= last_elem ? '0 : elem_idx + 1'b1;
                WR_BLK: begin
                    total   <= fold(tot_add, sat_q);
                    ovf_q   <= ovf_q | tot_add[DATA_W];
                    blk_sum <= '0;
                    base    <= base + ADDR_W'(BLOCK_LEN + 1);
                    blk_idx <= blk_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_accum_ctrl.sv
// Directed bench: a default instance and a RD_LAT=3/BLOCK_LEN=2/NUM_BLOCKS=2
// instance, each with a behavioural memory of matching read latency.
module tb_block_accum_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b, sat_en;

    logic [15:0] rdata_a, wdata_a, rdata_b, wdata_b;
    logic [4:0]  addr_a, addr_b;
    logic rd_a, wr_a, busy_a, done_a, ovf_a;
    logic rd_b, wr_b, busy_b, done_b, ovf_b;

    block_accum_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sat_en(sat_en),
        .mem_rdata(rdata_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rd_en(rd_a), .mem_wr_en(wr_a), .busy(busy_a), .done(done_a),
        .overflow(ovf_a)
    );

    block_accum_ctrl #(.RD_LAT(3), .BLOCK_LEN(2), .NUM_BLOCKS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sat_en(sat_en),
        .mem_rdata(rdata_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rd_en(rd_b), .mem_wr_en(wr_b), .busy(busy_b), .done(done_b),
        .overflow(ovf_b)
    );

    logic [15:0] mem_a [32];
    logic [15:0] mem_b [32];
    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];

    always @(posedge clk) begin
        pipe_a <= mem_a[addr_a];
        if (wr_a) mem_a[addr_a] = wdata_a;
    end
    always @(posedge clk) begin
        pipe_b[0] <= mem_b[addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (wr_b) mem_b[addr_b] = wdata_b;
    end
    assign rdata_a = pipe_a;
    assign rdata_b = pipe_b[2];

    int cyc = 0;
    int overlap = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if ((rd_a && wr_a) || (rd_b && wr_b)) overlap = overlap + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_a(input bit flat);
        for (int a = 0; a < 32; a++) mem_a[a] = 16'hDEAD;
        for (int b = 0; b < 5; b++)
            for (int e = 0; e < 4; e++)
                mem_a[b*5+e] = flat ? 16'h4000 : 16'(b*5 + e + 1);
    endtask

    int first_rd;

    // Called at a negedge; returns done cycle index, first cycle after start edge = 1.
    task automatic run_a(input bit hold, output int lat);
        int t0;
        start_a = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        if (!hold) start_a = 1'b0;
        sat_en   = 1'b0;
        lat      = -1;
        first_rd = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clk);
            if (rd_a && first_rd < 0) first_rd = cyc - t0 + 1;
            if (done_a) begin
                lat = cyc - t0 + 1;
                check("busy_low_at_done", busy_a, 0);
            end
        end
    endtask

    int rd_q[$];

    task automatic run_b(output int lat);
        int t0;
        start_b = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        start_b = 1'b0;
        lat = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clk);
            if (rd_b) rd_q.push_back(cyc - t0 + 1);
            if (done_b) lat = cyc - t0 + 1;
        end
    endtask

    int lat;
    int seen;
    logic [15:0] sums_a [5] = '{16'd10, 16'd30, 16'd50, 16'd70, 16'd90};
    int exp_rd_b [4] = '{1, 6, 12, 17};

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sat_en = 1'b0;
        load_a(1'b0);
        for (int a = 0; a < 32; a++) mem_b[a] = 16'hDEAD;
        repeat (3) @(negedge clk);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_strobes", {rd_a, wr_a}, 0);
        check("rst_busy_done", {busy_a, done_a}, 0);
        check("rst_ovf", ovf_a, 0);
        reset = 1'b0;
        @(negedge clk);

        // Address-ramp data: mem[a] = a+1.
        run_a(1'b0, lat);
        check("ramp_latency", lat, 67);
        check("ramp_first_rd", first_rd, 1);
        for (int b = 0; b < 5; b++) check($sformatf("ramp_blk%0d", b), mem_a[b*5+4], sums_a[b]);
        check("ramp_total", mem_a[31], 250);
        check("ramp_ovf", ovf_a, 0);
        @(negedge clk);
        check("done_one_cycle", done_a, 0);

        // Wrapping overflow.
        load_a(1'b1);
        run_a(1'b0, lat);
        check("wrap_blk0", mem_a[4], 16'h0000);
        check("wrap_blk4", mem_a[24], 16'h0000);
        check("wrap_total", mem_a[31], 16'h0000);
        check("wrap_ovf", ovf_a, 1);

        // Saturating; sat_en is dropped right after the start edge.
        load_a(1'b1);
        @(negedge clk);
        sat_en = 1'b1;
        run_a(1'b0, lat);
        for (int b = 0; b < 5; b++) check($sformatf("sat_blk%0d", b), mem_a[b*5+4], 16'hFFFF);
        check("sat_total", mem_a[31], 16'hFFFF);
        check("sat_ovf", ovf_a, 1);

        // Long-latency instance.
        mem_b[0] = 16'h0100; mem_b[1] = 16'h0023;
        mem_b[3] = 16'h1000; mem_b[4] = 16'h0005;
        @(negedge clk);
        run_b(lat);
        check("b_latency", lat, 24);
        check("b_rd_count", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check($sformatf("b_rd_cycle%0d", i), rd_q[i], exp_rd_b[i]);
        check("b_blk0", mem_b[2], 16'h0123);
        check("b_blk1", mem_b[5], 16'h1005);
        check("b_total", mem_b[31], 16'h1128);
        check("b_ovf", ovf_b, 0);

        // Reset in the third block, with start also high.
        load_a(1'b1);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy", busy_a, 1);
        check("mid_ovf", ovf_a, 1);
        reset = 1'b1; start_a = 1'b1;
        @(negedge clk);
        check("abort_strobes", {rd_a, wr_a}, 0);
        check("abort_busy_done", {busy_a, done_a}, 0);
        check("abort_addr_wdata", {addr_a, wdata_a}, 0);
        check("abort_ovf", ovf_a, 0);
        load_a(1'b0);
        reset = 1'b0;
        run_a(1'b0, lat);
        check("rerun_latency", lat, 67);
        check("rerun_blk2", mem_a[14], 16'd50);
        check("rerun_total", mem_a[31], 16'd250);

        // start held through a run, then a second run.
        load_a(1'b1);
        @(negedge clk);
        run_a(1'b1, lat);
        check("hold_latency", lat, 67);
        check("hold_ovf_after_done", ovf_a, 1);
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (busy_a) seen = 1;
        end
        check("hold_restart", seen, 1);
        check("hold_ovf_cleared", ovf_a, 0);
        start_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        check("hold_second_done", seen, 1);

        check("rd_wr_exclusive", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
